stream_mux_rr: RTL and testbench

Parametrised N-channel streaming multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage. It is the successor to the fixed 4-bit 2:1/4:1 combinational muxes: channel count and width are generic, and the select is produced internally by a fair arbiter rather than driven externally. It sits between several producer streams and a single consumer and tolerates consumer back-pressure without data loss.

---
 rtl/stream_mux_rr_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/stream_mux_rr.sv | 93 +++++++++
 tb/tb_stream_mux_rr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared defaults, index arithmetic and arbiter state for stream_mux_rr.
// Optional packet lock is enabled with STREAM_MUX_RR_LOCK_EN.
package stream_mux_rr_pkg;

  localparam int DEFAULT_W = 4;
  localparam int DEFAULT_N = 4;

  // Index storage is sized for up to 256 channels; users truncate to their SW.
  localparam int IDX_W = 8;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    idx_t ptr;
    logic locked;
    idx_t lk;
  } arb_state_t;

  // (base + off) mod n, valid for base < n and off < n.
  function automatic idx_t rot_idx(input idx_t base, input int unsigned off,
                                   input int unsigned n);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= n) sum = sum - n;
    return idx_t'(sum);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter with optional packet lock; owns ptr and lock state.
// Lock behaviour is inert unless lock_hold is driven (STREAM_MUX_RR_LOCK_EN).
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  input  logic          lock_hold,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  arb_state_t state;
  logic [SW-1:0] cand;

  // Walk offsets from the far end so the lowest offset from ptr wins last.
  always_comb begin
    grant = '0;
    grant_idx = '0;
    cand = '0;
    if (state.locked) begin
      cand = SW'(state.lk);
      if (req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx = cand;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        cand = SW'(rot_idx(state.ptr, unsigned'(i), N));
        if (req[cand]) begin
          grant = '0;
          grant[cand] = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (adv) begin
      if (lock_hold) begin
        state.locked <= 1'b1;
        state.lk <= idx_t'(grant_idx);
      end else begin
        state.locked <= 1'b0;
        state.ptr <= rot_idx(idx_t'(grant_idx), 1, N);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output.
// Define STREAM_MUX_RR_LOCK_EN to add in_last/out_last and hold the grant for whole packets.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
`ifdef STREAM_MUX_RR_LOCK_EN
  input  logic [N-1:0]   in_last,
  output logic           out_last,
`endif
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          load;
  logic          xfer;
  logic          lock_hold;
  logic [W-1:0]  sel_data;
`ifdef STREAM_MUX_RR_LOCK_EN
  logic          sel_last;
`endif

  assign load = ~out_valid | out_ready;
  assign xfer = (|grant) & load;
  // Gate with rst_n so producers never see a handshake while the register is held in reset.
  assign in_ready = (rst_n & load) ? grant : '0;

  always_comb begin
    sel_data = '0;
`ifdef STREAM_MUX_RR_LOCK_EN
    sel_last = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*W +: W];
`ifdef STREAM_MUX_RR_LOCK_EN
        sel_last = in_last[i];
`endif
      end
    end
  end

`ifdef STREAM_MUX_RR_LOCK_EN
  assign lock_hold = ~sel_last;
`else
  assign lock_hold = 1'b0;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .adv       (xfer),
    .lock_hold (lock_hold),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A new accept takes priority over a drain so back-to-back beats flow without bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= sel_data;
      out_sel <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_RR_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_last <= 1'b0;
    else if (xfer) out_last <= sel_last;
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (N=4, W=4).
// Lock-mode steps are compiled in when STREAM_MUX_RR_LOCK_EN is defined.
module tb_stream_mux_rr;

  localparam int W = 4;
  localparam int N = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
`ifdef STREAM_MUX_RR_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int testsRun = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_RR_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic v, input logic [SW-1:0] sel,
                           input logic [W-1:0] data);
    checkOutput({tag, " out_valid"}, 16'(out_valid), 16'(v));
    checkOutput({tag, " out_sel"}, 16'(out_sel), 16'(sel));
    checkOutput({tag, " out_data"}, 16'(out_data), 16'(data));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
    in_valid = v;
    in_data = d;
    out_ready = ordy;
    #1;
  endtask

  int sentCount;
  int rxCount;
  int cyc;
  logic firedIn;

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
`ifdef STREAM_MUX_RR_LOCK_EN
    in_last = '1;
`endif

    // Reset state, with producers already asserting valid
    applyStimulus(4'hF, 16'hDCBA, 1'b1);
    step();
    step();
    checkOutput("reset in_ready", 16'(in_ready), 16'h0);
    checkBeat("reset", 1'b0, 2'd0, 4'h0);
    rst_n = 1'b1;
    #1;

    // All channels valid: 0,1,2,3,0 one per cycle
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'hF, 16'hDCBA, 1'b1);
      checkOutput("rr in_ready", 16'(in_ready), 16'(1 << (k % 4)));
      step();
      checkBeat("rr beat", 1'b1, 2'(k % 4), 4'(4'hA + k % 4));
    end

    // Drain with no new input: data/sel hold
    applyStimulus(4'h0, 16'hDCBA, 1'b1);
    step();
    checkBeat("drain", 1'b0, 2'd0, 4'hA);

    // Back-pressure with channels 1 and 3
    applyStimulus(4'b1010, 16'hDCBA, 1'b0);
    checkOutput("bp first in_ready", 16'(in_ready), 16'b0010);
    step();
    checkBeat("bp load", 1'b1, 2'd1, 4'hB);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1000, 16'hDCBA, 1'b0);
      checkOutput("bp stall in_ready", 16'(in_ready), 16'h0);
      step();
      checkBeat("bp hold", 1'b1, 2'd1, 4'hB);
    end
    applyStimulus(4'b1000, 16'hDCBA, 1'b1);
    checkOutput("bp release in_ready", 16'(in_ready), 16'b1000);
    step();
    checkBeat("bp second", 1'b1, 2'd3, 4'hD);
    applyStimulus(4'h0, 16'hDCBA, 1'b1);
    step();
    checkBeat("bp drain", 1'b0, 2'd3, 4'hD);

    // Wrap-around: serve 2 (ptr=3), then only 0 valid, then ptr must be 1
    applyStimulus(4'b0100, 16'hDCBA, 1'b1);
    checkOutput("wrap ch2 in_ready", 16'(in_ready), 16'b0100);
    step();
    checkBeat("wrap ch2", 1'b1, 2'd2, 4'hC);
    applyStimulus(4'b0001, 16'hDCBA, 1'b1);
    checkOutput("wrap ch0 in_ready", 16'(in_ready), 16'b0001);
    step();
    checkBeat("wrap ch0", 1'b1, 2'd0, 4'hA);
    applyStimulus(4'b1011, 16'hDCBA, 1'b1);
    checkOutput("wrap ptr1 in_ready", 16'(in_ready), 16'b0010);
    step();
    checkBeat("wrap ptr1", 1'b1, 2'd1, 4'hB);
    applyStimulus(4'h0, 16'h0, 1'b1);
    step();
    checkOutput("wrap drain", 16'(out_valid), 16'h0);

    // Channel 2 streams 10 beats with out_ready toggling 1,0,1,0
    sentCount = 0;
    rxCount = 0;
    cyc = 0;
    while (rxCount < 10 && cyc < 60) begin
      applyStimulus((sentCount < 10) ? 4'b0100 : 4'b0000, 16'(sentCount) << 8, (cyc % 2) == 0);
      firedIn = in_ready[2];
      if (out_valid && out_ready) begin
        checkOutput("stream data", 16'(out_data), 16'(rxCount));
        checkOutput("stream sel", 16'(out_sel), 16'd2);
        rxCount++;
      end
      step();
      if (firedIn) sentCount++;
      cyc++;
    end
    checkOutput("stream rx count", 16'(rxCount), 16'd10);
    checkOutput("stream tx count", 16'(sentCount), 16'd10);
    applyStimulus(4'h0, 16'h0, 1'b1);
    step();
    checkOutput("stream no extra beat", 16'(out_valid), 16'h0);

    // Asynchronous reset mid-stream while holding a channel-2 beat
    applyStimulus(4'b0100, 16'h0500, 1'b0);
    step();
    checkBeat("pre-reset", 1'b1, 2'd2, 4'h5);
    #2;
    rst_n = 1'b0;
    #1;
    checkBeat("async reset", 1'b0, 2'd0, 4'h0);
    checkOutput("async reset in_ready", 16'(in_ready), 16'h0);
    applyStimulus(4'hF, 16'hDCBA, 1'b1);
    checkOutput("in reset in_ready", 16'(in_ready), 16'h0);
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 16'(in_ready), 16'b0001);
    step();
    checkBeat("post-reset beat", 1'b1, 2'd0, 4'hA);

`ifdef STREAM_MUX_RR_LOCK_EN
    // Packet lock: channel 1 sends 3 beats while channel 2 waits
    applyStimulus(4'h0, 16'h0, 1'b1);
    step();
    in_last = 4'b0000;
    applyStimulus(4'b0110, 16'h0E10, 1'b1);
    checkOutput("lock b1 in_ready", 16'(in_ready), 16'b0010);
    step();
    checkBeat("lock b1", 1'b1, 2'd1, 4'h1);
    checkOutput("lock b1 out_last", 16'(out_last), 16'h0);
    applyStimulus(4'b0110, 16'h0E20, 1'b1);
    checkOutput("lock b2 in_ready", 16'(in_ready), 16'b0010);
    step();
    checkBeat("lock b2", 1'b1, 2'd1, 4'h2);
    applyStimulus(4'b0100, 16'h0E00, 1'b1);
    checkOutput("lock stall in_ready", 16'(in_ready), 16'h0);
    step();
    checkOutput("lock stall drain", 16'(out_valid), 16'h0);
    in_last = 4'b0010;
    applyStimulus(4'b0110, 16'h0E30, 1'b1);
    checkOutput("lock b3 in_ready", 16'(in_ready), 16'b0010);
    step();
    checkBeat("lock b3", 1'b1, 2'd1, 4'h3);
    checkOutput("lock b3 out_last", 16'(out_last), 16'h1);
    in_last = 4'b0100;
    applyStimulus(4'b0100, 16'h0E00, 1'b1);
    checkOutput("lock ch2 in_ready", 16'(in_ready), 16'b0100);
    step();
    checkBeat("lock ch2", 1'b1, 2'd2, 4'hE);
    checkOutput("lock ch2 out_last", 16'(out_last), 16'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
